multicycle_control: RTL and testbench

- Multi-cycle control FSM that sequences the MIPS-subset datapath: fetch, decode, execute, memory, writeback.
- Drives the register-file, ALU and memory control strobes one phase at a time instead of the single-cycle decode.
- Handshakes with instruction and data memories, traps on illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/multicycle_control.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the MIPS-subset datapath: fetch, decode, execute,
// memory, writeback, with memory timeouts, illegal-opcode trap and retire counter.
module multicycle_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop_req,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_load,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic             memread,
  output logic             memwrite,
  output logic             alu_en,
  output logic [3:0]       aluOp,
  output logic             immReg,
  output logic             regDst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             pc_en,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired_count
);

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    C_ADD, C_SUB, C_AND, C_ADDI, C_LW, C_SW
  } cls_e;

  state_e            state_q;
  cls_e              cls_q, cls_d;
  logic              legal_d;
  logic [WW-1:0]     wait_q;
  logic              stop_q;
  logic [1:0]        cause_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              retire;
  logic              stopping;

  // Instruction class decode; only consumed on the DECODE edge.
  always_comb begin
    legal_d = 1'b1;
    cls_d   = C_ADD;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: cls_d = C_ADD;
          6'h22:        cls_d = C_SUB;
          6'h24:        cls_d = C_AND;
          default:      legal_d = 1'b0;
        endcase
      end
      6'h08:   cls_d = C_ADDI;
      6'h23:   cls_d = C_LW;
      6'h2B:   cls_d = C_SW;
      default: legal_d = 1'b0;
    endcase
  end

  assign retire   = (state_q == S_WB) ||
                    (state_q == S_MEM && cls_q == C_SW && dmem_ack);
  assign stopping = stop_q | stop_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= C_ADD;
      wait_q  <= '0;
      stop_q  <= 1'b0;
      cause_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      if (state_q != S_TRAP && stop_req) stop_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            state_q <= S_DECODE;
          end else if (wait_q == WAIT_LAST) begin
            state_q <= S_TRAP;
            cause_q <= 2'b10;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_DECODE: begin
          if (legal_d) begin
            cls_q   <= cls_d;
            state_q <= S_EXEC;
          end else begin
            state_q <= S_TRAP;
            cause_q <= 2'b01;
          end
        end
        S_EXEC: begin
          if (cls_q == C_LW || cls_q == C_SW) begin
            state_q <= S_MEM;
            wait_q  <= '0;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (cls_q == C_LW) state_q <= S_WB;
          end else if (wait_q == WAIT_LAST) begin
            state_q <= S_TRAP;
            cause_q <= 2'b11;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_WB:    ;
        default: state_q <= S_TRAP;
      endcase
      // Retire overrides the per-state next state chosen above.
      if (retire) begin
        cnt_q <= cnt_q + 1'b1;
        if (stopping) begin
          state_q <= S_IDLE;
          stop_q  <= 1'b0;
        end else begin
          state_q <= S_FETCH;
          wait_q  <= '0;
        end
      end
    end
  end

  always_comb begin
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    alu_en   = 1'b0;
    aluOp    = 4'b0000;
    immReg   = 1'b0;
    regDst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    pc_en    = retire;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        aluOp  = (cls_q == C_SUB) ? 4'b0001 : (cls_q == C_AND) ? 4'b0010 : 4'b0000;
        immReg = (cls_q == C_ADDI || cls_q == C_LW || cls_q == C_SW);
      end
      S_MEM: begin
        dmem_req = 1'b1;
        memread  = (cls_q == C_LW);
        memwrite = (cls_q == C_SW);
        immReg   = 1'b1;
      end
      S_WB: begin
        regwrite = 1'b1;
        regDst   = (cls_q == C_ADD || cls_q == C_SUB || cls_q == C_AND);
        memtoreg = (cls_q == C_LW);
      end
      default: ;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign trap          = (state_q == S_TRAP);
  assign trap_cause    = cause_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: each instruction is expanded into its expected phase sequence
// from the ISA rules and every cycle's strobes are compared against it.
module tb_multicycle_control;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;
  localparam int PI = 0, PF = 1, PD = 2, PE = 3, PM = 4, PW = 5, PT = 6;

  logic clk = 1'b0;
  logic rst, start, stop_req, imem_ack, dmem_ack;
  logic [5:0] opcode, funct;
  logic imem_req, ir_load, dmem_req, memread, memwrite, alu_en;
  logic [3:0] aluOp;
  logic immReg, regDst, memtoreg, regwrite, pc_en, busy, trap;
  logic [1:0] trap_cause;
  logic [CNT_W-1:0] retired_count;
  logic [16:0] obs;

  int n_cmp = 0, n_bad = 0;
  int exp_cnt = 0;
  bit idle = 1'b1;

  multicycle_control #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop_req(stop_req),
    .opcode(opcode), .funct(funct),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .memread(memread), .memwrite(memwrite), .alu_en(alu_en), .aluOp(aluOp),
    .immReg(immReg), .regDst(regDst), .memtoreg(memtoreg), .regwrite(regwrite),
    .pc_en(pc_en), .busy(busy), .trap(trap), .trap_cause(trap_cause),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  assign obs = {busy, trap, imem_req, ir_load, dmem_req, memread, memwrite, alu_en,
                aluOp, immReg, regDst, memtoreg, regwrite, pc_en};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // 0 add/addu, 1 sub, 2 and, 3 addi, 4 lw, 5 sw, -1 illegal
  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h20 || fn == 6'h21) return 0;
      if (fn == 6'h22) return 1;
      if (fn == 6'h24) return 2;
      return -1;
    end
    if (op == 6'h08) return 3;
    if (op == 6'h23) return 4;
    if (op == 6'h2B) return 5;
    return -1;
  endfunction

  function automatic logic [16:0] expv(input int ph, input int k, input bit last);
    logic bz, tr, ir, il, dr, mr, mw, ae, im, rd, mt, rw, pc;
    logic [3:0] ao;
    {tr, ir, il, dr, mr, mw, ae, im, rd, mt, rw, pc} = '0;
    ao = 4'd0;
    bz = (ph != PI);
    case (ph)
      PF: begin ir = 1; il = last; end
      PE: begin
        ae = 1;
        ao = (k == 1) ? 4'd1 : (k == 2) ? 4'd2 : 4'd0;
        im = (k >= 3);
      end
      PM: begin dr = 1; mr = (k == 4); mw = (k == 5); im = 1; pc = (k == 5) && last; end
      PW: begin rw = 1; rd = (k < 3); mt = (k == 4); pc = 1; end
      PT: tr = 1;
      default: ;
    endcase
    return {bz, tr, ir, il, dr, mr, mw, ae, ao, im, rd, mt, rw, pc};
  endfunction

  task automatic junk();
    opcode = 6'($urandom);
    funct  = 6'($urandom);
  endtask

  task automatic step(input string tag, input logic [16:0] e);
    #1 chk(tag, obs, e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_strobes", obs, 17'd0);
    chk("rst_cause", trap_cause, 2'b00);
    chk("rst_count", retired_count, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    idle = 1'b1;
  endtask

  task automatic trap_check(input logic [1:0] cause);
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom_range(0, 1));
      stop_req = 1'($urandom_range(0, 1));
      step("trap", expv(PT, 0, 0));
    end
    chk("trap_cause", trap_cause, cause);
    start = 1'b0;
    stop_req = 1'b0;
    do_reset();
  endtask

  task automatic kick();
    if (idle) begin
      start = 1'b1;
      junk();
      step("idle", expv(PI, 0, 0));
      start = 1'b0;
      stop_req = 1'b0;
    end
  endtask

  // mw: >=0 ack after mw waits, -1 never ack (timeout), -2 reset during first MEM cycle
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input bit stop);
    int k;
    bit stop_early;
    k = kind_of(op, fn);
    stop_early = idle && stop && ($urandom_range(0, 1) == 1);
    stop_req = stop_early;
    kick();
    for (int i = 0; i <= fw; i++) begin
      imem_ack = (i == fw);
      start = 1'($urandom_range(0, 1));
      junk();
      step("fetch", expv(PF, k, i == fw));
    end
    imem_ack = 1'b0;
    start = 1'b0;
    opcode = op;
    funct = fn;
    step("decode", expv(PD, k, 0));
    junk();
    if (k < 0) begin
      trap_check(2'b01);
      return;
    end
    stop_req = stop && !stop_early;
    step("exec", expv(PE, k, 0));
    stop_req = 1'b0;
    if (k >= 4) begin
      if (mw == -2) begin
        dmem_ack = 1'b0;
        #1 chk("mem_pre_rst", obs, expv(PM, k, 0));
        rst = 1'b1;
        #1 chk("mem_async_rst", obs, 17'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        idle = 1'b1;
        chk("mem_rst_count", retired_count, 0);
        return;
      end
      if (mw == -1) begin
        dmem_ack = 1'b0;
        for (int j = 0; j < TIMEOUT; j++) step("mem_wait", expv(PM, k, 0));
        trap_check(2'b11);
        return;
      end
      for (int j = 0; j <= mw; j++) begin
        dmem_ack = (j == mw);
        step("mem", expv(PM, k, j == mw));
      end
      dmem_ack = 1'b0;
    end
    if (k != 5) step("wb", expv(PW, k, 1));
    exp_cnt++;
    idle = stop;
    #1 chk("retired", retired_count, exp_cnt);
    chk("busy_after", busy, !stop);
  endtask

  task automatic fetch_timeout();
    kick();
    imem_ack = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      junk();
      step("fetch_wait", expv(PF, 0, 0));
    end
    trap_check(2'b10);
  endtask

  logic [5:0] lop [7];
  logic [5:0] lfn [4];

  initial begin
    lop = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B};
    lfn = '{6'h20, 6'h21, 6'h22, 6'h24};
    rst = 1'b1; start = 0; stop_req = 0; imem_ack = 0; dmem_ack = 0;
    opcode = 0; funct = 0;
    repeat (2) @(negedge clk);
    chk("reset_strobes", obs, 17'd0);
    chk("reset_cause", trap_cause, 2'b00);
    chk("reset_count", retired_count, 0);
    rst = 1'b0;
    @(negedge clk);

    run_instr(6'h00, 6'h20, 0, 0, 0);
    run_instr(6'h00, 6'h22, 0, 0, 0);
    run_instr(6'h00, 6'h24, 0, 0, 0);
    run_instr(6'h23, 6'h11, 0, 3, 0);
    run_instr(6'h2B, 6'h05, 0, 0, 0);
    run_instr(6'h08, 6'h3A, 2, 0, 1);
    run_instr(6'h00, 6'h21, 1, 0, 0);
    run_instr(6'h3F, 6'h20, 0, 0, 0);
    fetch_timeout();
    run_instr(6'h23, 6'h00, 0, -1, 0);
    run_instr(6'h2B, 6'h00, 0, -2, 0);

    for (int n = 0; n < 120; n++) begin
      logic [5:0] op, fn;
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        do begin
          op = 6'($urandom);
          fn = 6'($urandom);
        end while (kind_of(op, fn) >= 0);
      end else begin
        r = $urandom_range(0, 6);
        op = lop[r];
        fn = (r < 4) ? lfn[r] : 6'($urandom);
      end
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
